// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: drains bytes from a UART receiver and assembles frames of the
// form SYNC, CMD, PAYLOAD (PAYLOAD_BYTES bytes, MSB first), CHK. It checks an
// 8-bit wrap-around checksum, enforces an inter-byte timeout, and hands a
// validated command to the consumer with a ready/clear handshake.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   rx_rdy         receiver has a byte waiting
//   rx_data        byte from the receiver
//   clr_rx_rdy     one-cycle acknowledge to the receiver
//   cmd_rdy        level: a valid command is held on cmd/data
//   clr_cmd_rdy    consumer acknowledges the command
//   cmd, data      command byte and payload (first payload byte in MSBs)
//   chk_err        one-cycle pulse on checksum mismatch
//   to_err         one-cycle pulse on inter-byte timeout
//   cmd_ovr        one-cycle pulse when an uncleared command is overwritten
module uart_cmd_rcv #(
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned PAYLOAD_BYTES = 2,
    parameter int unsigned TIMEOUT_CLKS  = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_rdy,
    input  logic [7:0]                 rx_data,
    output logic                       clr_rx_rdy,
    output logic                       cmd_rdy,
    input  logic                       clr_cmd_rdy,
    output logic [7:0]                 cmd,
    output logic [8*PAYLOAD_BYTES-1:0] data,
    output logic                       chk_err,
    output logic                       to_err,
    output logic                       cmd_ovr
);

    localparam int unsigned DATA_W = 8 * PAYLOAD_BYTES;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_CMD,
        ST_DATA,
        ST_CHK
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cmd_sh_q, cmd_sh_d;
    logic [DATA_W-1:0]   data_sh_q, data_sh_d;
    logic [7:0]          sum_q, sum_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                cmd_rdy_q, cmd_rdy_d;
    logic                clr_rx_rdy_q, clr_rx_rdy_d;
    logic                chk_err_q, chk_err_d;
    logic                to_err_q, to_err_d;
    logic                cmd_ovr_q, cmd_ovr_d;
    logic                accept;

    // A byte is taken once; rx_rdy is ignored during the acknowledge cycle.
    assign accept = rx_rdy && !clr_rx_rdy_q;

    // Next-state and output computation.
    always_comb begin
        state_d      = state_q;
        cmd_sh_d     = cmd_sh_q;
        data_sh_d    = data_sh_q;
        sum_d        = sum_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        cmd_rdy_d    = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
        clr_rx_rdy_d = accept;
        chk_err_d    = 1'b0;
        to_err_d     = 1'b0;
        cmd_ovr_d    = 1'b0;

        case (state_q)
            ST_SYNC: begin
                tmo_d = '0;
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (accept) begin
                    cmd_sh_d = rx_data;
                    sum_d    = rx_data;
                    idx_d    = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    data_sh_d = (data_sh_q << 8) | DATA_W'(rx_data);
                    sum_d     = sum_q + rx_data;
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        cmd_d     = cmd_sh_q;
                        data_d    = data_sh_q;
                        // Set wins over a simultaneous clear.
                        cmd_rdy_d = 1'b1;
                        cmd_ovr_d = cmd_rdy_q && !clr_cmd_rdy;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    state_d = ST_SYNC;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        // Inter-byte timeout while a frame is in progress.
        if (state_q != ST_SYNC) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CLKS - 1)) begin
                tmo_d    = '0;
                state_d  = ST_SYNC;
                to_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_SYNC;
            cmd_sh_q     <= '0;
            data_sh_q    <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            cmd_q        <= '0;
            data_q       <= '0;
            cmd_rdy_q    <= 1'b0;
            clr_rx_rdy_q <= 1'b0;
            chk_err_q    <= 1'b0;
            to_err_q     <= 1'b0;
            cmd_ovr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_sh_q     <= cmd_sh_d;
            data_sh_q    <= data_sh_d;
            sum_q        <= sum_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            cmd_rdy_q    <= cmd_rdy_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            chk_err_q    <= chk_err_d;
            to_err_q     <= to_err_d;
            cmd_ovr_q    <= cmd_ovr_d;
        end
    end

    assign clr_rx_rdy = clr_rx_rdy_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign cmd        = cmd_q;
    assign data       = data_q;
    assign chk_err    = chk_err_q;
    assign to_err     = to_err_q;
    assign cmd_ovr    = cmd_ovr_q;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv with a short timeout and 2-byte payload.
module tb_uart_cmd_rcv;

    localparam int unsigned PB  = 2;
    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        clr_rx_rdy, cmd_rdy, chk_err, to_err, cmd_ovr;
    logic [7:0]  cmd;
    logic [15:0] data;

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0, chk_cnt = 0, to_cnt = 0, ovr_cnt = 0, bytes_sent = 0;
    int chk0, to0, ovr0;

    uart_cmd_rcv #(
        .SYNC_BYTE    (8'hA5),
        .PAYLOAD_BYTES(PB),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .data       (data),
        .chk_err    (chk_err),
        .to_err     (to_err),
        .cmd_ovr    (cmd_ovr)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (clr_rx_rdy === 1'b1) clr_cnt++;
        if (chk_err === 1'b1) chk_cnt++;
        if (to_err === 1'b1) to_cnt++;
        if (cmd_ovr === 1'b1) ovr_cnt++;
    end

    task automatic snap();
        chk0 = chk_cnt; to0 = to_cnt; ovr0 = ovr_cnt;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Present one byte; rx_rdy stays high through the acknowledge cycle.
    task automatic send_byte(input logic [7:0] b, input logic clr_on_accept);
        @(negedge clk);
        rx_rdy = 1'b1; rx_data = b; clr_cmd_rdy = clr_on_accept;
        @(posedge clk); #1;
        checks++;
        if (clr_rx_rdy !== 1'b1) begin
            errors++; $display("FAIL clr_rx_rdy_ack byte=%h: got %b expected 1", b, clr_rx_rdy);
        end
        bytes_sent++;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [15:0] d,
                              input logic [7:0] ck, input logic clr_on_chk);
        send_byte(8'hA5, 1'b0); repeat (20) @(negedge clk);
        send_byte(c, 1'b0);     repeat (20) @(negedge clk);
        send_byte(d[15:8], 1'b0); repeat (20) @(negedge clk);
        send_byte(d[7:0], 1'b0);  repeat (20) @(negedge clk);
        send_byte(ck, clr_on_chk);
    endtask

    task automatic clear_cmd();
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        #1;
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++; $display("FAIL cmd_rdy_clear: got %b expected 0", cmd_rdy);
        end
    endtask

    task automatic check_cmd(input string nm, input logic rdy, input logic [7:0] c,
                             input logic [15:0] d);
        checks++;
        if (cmd_rdy !== rdy) begin
            errors++; $display("FAIL %s cmd_rdy: got %b expected %b", nm, cmd_rdy, rdy);
        end
        checks++;
        if (cmd !== c) begin
            errors++; $display("FAIL %s cmd: got %h expected %h", nm, cmd, c);
        end
        checks++;
        if (data !== d) begin
            errors++; $display("FAIL %s data: got %h expected %h", nm, data, d);
        end
    endtask

    task automatic check_pulses(input string nm, input int dchk, input int dto, input int dovr);
        checks++;
        if (chk_cnt - chk0 !== dchk) begin
            errors++; $display("FAIL %s chk_err pulses: got %0d expected %0d", nm, chk_cnt - chk0, dchk);
        end
        checks++;
        if (to_cnt - to0 !== dto) begin
            errors++; $display("FAIL %s to_err pulses: got %0d expected %0d", nm, to_cnt - to0, dto);
        end
        checks++;
        if (ovr_cnt - ovr0 !== dovr) begin
            errors++; $display("FAIL %s cmd_ovr pulses: got %0d expected %0d", nm, ovr_cnt - ovr0, dovr);
        end
        checks++;
        if (clr_cnt !== bytes_sent) begin
            errors++; $display("FAIL %s clr_rx_rdy pulses: got %0d expected %0d", nm, clr_cnt, bytes_sent);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_cmd("reset", 1'b0, 8'h00, 16'h0000);
        checks++;
        if ({clr_rx_rdy, chk_err, to_err, cmd_ovr} !== 4'b0000) begin
            errors++; $display("FAIL reset pulses: got %b expected 0000", {clr_rx_rdy, chk_err, to_err, cmd_ovr});
        end
    endtask

    task automatic test_valid_frame();
        snap();
        send_frame(8'h10, 16'h1234, 8'h56, 1'b0);
        settle();
        check_cmd("valid", 1'b1, 8'h10, 16'h1234);
        check_pulses("valid", 0, 0, 0);
        clear_cmd();
        check_cmd("valid_after_clear", 1'b0, 8'h10, 16'h1234);
    endtask

    task automatic test_chk_err();
        snap();
        send_frame(8'h10, 16'h1234, 8'h57, 1'b0);
        settle();
        check_cmd("bad_chk", 1'b0, 8'h10, 16'h1234);
        check_pulses("bad_chk", 1, 0, 0);
        send_frame(8'h01, 16'h00FF, 8'h00, 1'b0);
        settle();
        check_cmd("wrap_chk", 1'b1, 8'h01, 16'h00FF);
        check_pulses("wrap_chk", 1, 0, 0);
        clear_cmd();
    endtask

    task automatic test_garbage();
        snap();
        send_byte(8'h00, 1'b0); repeat (5) @(negedge clk);
        send_byte(8'hFF, 1'b0); repeat (5) @(negedge clk);
        send_byte(8'h3C, 1'b0);
        settle();
        check_cmd("garbage", 1'b0, 8'h01, 16'h00FF);
        check_pulses("garbage", 0, 0, 0);
        send_frame(8'h10, 16'h1234, 8'h56, 1'b0);
        settle();
        check_cmd("after_garbage", 1'b1, 8'h10, 16'h1234);
        check_pulses("after_garbage", 0, 0, 0);
        clear_cmd();
    endtask

    task automatic test_timeout();
        snap();
        send_byte(8'hA5, 1'b0); repeat (20) @(negedge clk);
        send_byte(8'h10, 1'b0); repeat (20) @(negedge clk);
        send_byte(8'h12, 1'b0);
        // Now just past the second edge after 12 was taken.
        repeat (98) @(negedge clk);
        checks++;
        if (to_err !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got %b expected 0 at clk 99", to_err);
        end
        @(negedge clk);
        checks++;
        if (to_err !== 1'b1) begin
            errors++; $display("FAIL timeout_edge: got %b expected 1 at clk 100", to_err);
        end
        @(negedge clk);
        checks++;
        if (to_err !== 1'b0) begin
            errors++; $display("FAIL timeout_width: got %b expected 0 at clk 101", to_err);
        end
        settle();
        check_pulses("timeout", 0, 1, 0);
        send_frame(8'h10, 16'h1234, 8'h56, 1'b0);
        settle();
        check_cmd("after_timeout", 1'b1, 8'h10, 16'h1234);
        check_pulses("after_timeout", 0, 1, 0);
        clear_cmd();
    endtask

    task automatic test_overwrite();
        snap();
        send_frame(8'h10, 16'h1234, 8'h56, 1'b0);
        settle();
        send_frame(8'h20, 16'h1234, 8'h66, 1'b0);
        settle();
        check_cmd("overwrite", 1'b1, 8'h20, 16'h1234);
        check_pulses("overwrite", 0, 0, 1);
        send_frame(8'h30, 16'h1234, 8'h76, 1'b1);
        settle();
        check_cmd("set_wins", 1'b1, 8'h30, 16'h1234);
        check_pulses("set_wins", 0, 0, 1);
        clear_cmd();
    endtask

    task automatic test_mid_reset();
        send_frame(8'h10, 16'h1234, 8'h56, 1'b0);
        settle();
        check_cmd("pre_reset", 1'b1, 8'h10, 16'h1234);
        send_byte(8'hA5, 1'b0); repeat (5) @(negedge clk);
        send_byte(8'h10, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check_cmd("mid_reset", 1'b0, 8'h00, 16'h0000);
        snap();
        send_byte(8'h12, 1'b0); repeat (5) @(negedge clk);
        send_byte(8'h34, 1'b0); repeat (5) @(negedge clk);
        send_byte(8'h56, 1'b0);
        settle();
        check_cmd("post_reset_ignored", 1'b0, 8'h00, 16'h0000);
        check_pulses("post_reset_ignored", 0, 0, 0);
        send_frame(8'h20, 16'h1234, 8'h66, 1'b0);
        settle();
        check_cmd("post_reset_frame", 1'b1, 8'h20, 16'h1234);
        check_pulses("post_reset_frame", 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_chk_err();
        test_garbage();
        test_timeout();
        test_overwrite();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
